// File: rtl/pipe_decode_if.sv
// Handshake/bus interfaces for the pipe_decode stage.
//
// pipe_decode_in_if  : fetch -> decode stream
//   in_valid  fetch presents inst/pc_in
//   in_ready  decoder accepts this cycle
//   inst      32-bit instruction word
//   pc_in     PC of inst (XLEN bits)
//   modports: master (fetch side), slave (decoder side)
//
// pipe_decode_out_if : decode -> execute stream
//   out_valid decoded bundle valid
//   out_ready execute consumes bundle
//   pc_out, alu_op, alu_c, rd, opr1, opr2, val,
//   jp_e, br_e, wb_e, rw_e, rw_len, illegal : decoded bundle
//   modports: master (decoder side), slave (execute side)

interface pipe_decode_in_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     inst;
    logic [XLEN-1:0] pc_in;

    modport master (output in_valid, output inst, output pc_in, input in_ready);
    modport slave  (input in_valid, input inst, input pc_in, output in_ready);
endinterface

interface pipe_decode_out_if #(
    parameter int XLEN    = 32,
    parameter int ALUOP_L = 5
);
    logic               out_valid;
    logic               out_ready;
    logic [XLEN-1:0]    pc_out;
    logic [ALUOP_L-1:0] alu_op;
    logic               alu_c;
    logic [4:0]         rd;
    logic [XLEN-1:0]    opr1;
    logic [XLEN-1:0]    opr2;
    logic [XLEN-1:0]    val;
    logic               jp_e;
    logic               br_e;
    logic               wb_e;
    logic [1:0]         rw_e;
    logic [1:0]         rw_len;
    logic               illegal;

    modport master (
        output out_valid, output pc_out, output alu_op, output alu_c, output rd,
        output opr1, output opr2, output val, output jp_e, output br_e,
        output wb_e, output rw_e, output rw_len, output illegal,
        input  out_ready
    );
    modport slave (
        input  out_valid, input pc_out, input alu_op, input alu_c, input rd,
        input  opr1, input opr2, input val, input jp_e, input br_e,
        input  wb_e, input rw_e, input rw_len, input illegal,
        output out_ready
    );
endinterface

// File: rtl/pipe_decode.sv
// pipe_decode: RV32I instruction-decode stage with a one-cycle pipeline
// register and valid/ready handshakes on both sides.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   fe  (slave)         fetch stream: in_valid/in_ready/inst/pc_in
//   ex  (master)        execute stream: out_valid/out_ready + decoded bundle
//   flush               kill the held bundle and refuse the incoming inst
//   rs1_idx, rs2_idx    register-file read addresses (combinational from inst)
//   rs1_data, rs2_data  register-file read data, sampled on input transfer
//
// Build option: define PIPE_DECODE_RV32M_EN to decode the RV32M multiply/
// divide group (OP, funct7=0000001); otherwise those encodings are illegal.

module pipe_decode #(
    parameter int XLEN    = 32,
    parameter int ALUOP_L = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    pipe_decode_in_if.slave     fe,
    pipe_decode_out_if.master   ex,
    input  logic                flush,
    output logic [4:0]          rs1_idx,
    output logic [4:0]          rs2_idx,
    input  logic [XLEN-1:0]     rs1_data,
    input  logic [XLEN-1:0]     rs2_data
);

    // ALU operation encodings shared with the execute stage
    localparam logic [ALUOP_L-1:0] ALU_ADD    = ALUOP_L'(0);
    localparam logic [ALUOP_L-1:0] ALU_SUB    = ALUOP_L'(1);
    localparam logic [ALUOP_L-1:0] ALU_SLL    = ALUOP_L'(2);
    localparam logic [ALUOP_L-1:0] ALU_SLT    = ALUOP_L'(3);
    localparam logic [ALUOP_L-1:0] ALU_SLTU   = ALUOP_L'(4);
    localparam logic [ALUOP_L-1:0] ALU_XOR    = ALUOP_L'(5);
    localparam logic [ALUOP_L-1:0] ALU_SRL    = ALUOP_L'(6);
    localparam logic [ALUOP_L-1:0] ALU_SRA    = ALUOP_L'(7);
    localparam logic [ALUOP_L-1:0] ALU_OR     = ALUOP_L'(8);
    localparam logic [ALUOP_L-1:0] ALU_AND    = ALUOP_L'(9);
    localparam logic [ALUOP_L-1:0] ALU_SEQ    = ALUOP_L'(10);
    localparam logic [ALUOP_L-1:0] ALU_PASS   = ALUOP_L'(11);
`ifdef PIPE_DECODE_RV32M_EN
    localparam logic [ALUOP_L-1:0] ALU_MUL    = ALUOP_L'(16);
    localparam logic [ALUOP_L-1:0] ALU_MULH   = ALUOP_L'(17);
    localparam logic [ALUOP_L-1:0] ALU_MULHSU = ALUOP_L'(18);
    localparam logic [ALUOP_L-1:0] ALU_MULHU  = ALUOP_L'(19);
    localparam logic [ALUOP_L-1:0] ALU_DIV    = ALUOP_L'(20);
    localparam logic [ALUOP_L-1:0] ALU_DIVU   = ALUOP_L'(21);
    localparam logic [ALUOP_L-1:0] ALU_REM    = ALUOP_L'(22);
    localparam logic [ALUOP_L-1:0] ALU_REMU   = ALUOP_L'(23);
`endif

    typedef enum logic [6:0] {
        OPC_LUI      = 7'b0110111,
        OPC_AUIPC    = 7'b0010111,
        OPC_JAL      = 7'b1101111,
        OPC_JALR     = 7'b1100111,
        OPC_BRANCH   = 7'b1100011,
        OPC_LOAD     = 7'b0000011,
        OPC_STORE    = 7'b0100011,
        OPC_OP_IMM   = 7'b0010011,
        OPC_OP       = 7'b0110011,
        OPC_MISC_MEM = 7'b0001111,
        OPC_SYSTEM   = 7'b1110011
    } opcode_e;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [ALUOP_L-1:0] alu_op;
        logic               alu_c;
        logic [4:0]         rd;
        logic [XLEN-1:0]    opr1;
        logic [XLEN-1:0]    opr2;
        logic [XLEN-1:0]    val;
        logic               jp_e;
        logic               br_e;
        logic               wb_e;
        logic [1:0]         rw_e;
        logic [1:0]         rw_len;
        logic               illegal;
    } bundle_t;

    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_j;

    bundle_t dec;
    bundle_t held;
    logic    held_valid;
    logic    ill;
    logic    use_rs1;
    logic    use_rs2;
    logic    stall;
    logic    in_fire;
    logic    out_fire;

    assign funct3  = fe.inst[14:12];
    assign funct7  = fe.inst[31:25];
    assign rs1_idx = fe.inst[19:15];
    assign rs2_idx = fe.inst[24:20];

    assign imm_i = XLEN'($signed(fe.inst[31:20]));
    assign imm_s = XLEN'($signed({fe.inst[31:25], fe.inst[11:7]}));
    assign imm_b = XLEN'($signed({fe.inst[31], fe.inst[7], fe.inst[30:25], fe.inst[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({fe.inst[31:12], 12'b0}));
    assign imm_j = XLEN'($signed({fe.inst[31], fe.inst[19:12], fe.inst[20], fe.inst[30:21], 1'b0}));

    always_comb begin
        dec        = '0;
        dec.pc     = fe.pc_in;
        dec.alu_op = ALU_ADD;
        ill        = 1'b0;
        use_rs1    = 1'b0;
        use_rs2    = 1'b0;

        case (opcode_e'(fe.inst[6:0]))
            OPC_LUI: begin
                dec.alu_op = ALU_PASS;
                dec.opr1   = imm_u;
                dec.wb_e   = 1'b1;
            end
            OPC_AUIPC: begin
                dec.opr1 = fe.pc_in;
                dec.opr2 = imm_u;
                dec.wb_e = 1'b1;
            end
            OPC_JAL: begin
                dec.opr1 = imm_j;
                dec.opr2 = fe.pc_in;
                dec.val  = XLEN'(4);
                dec.jp_e = 1'b1;
                dec.wb_e = 1'b1;
            end
            OPC_JALR: begin
                use_rs1  = 1'b1;
                dec.opr1 = rs1_data;
                dec.opr2 = imm_i;
                dec.val  = XLEN'(4);
                dec.jp_e = 1'b1;
                dec.wb_e = 1'b1;
                if (funct3 != 3'b000) ill = 1'b1;
            end
            OPC_OP_IMM: begin
                use_rs1  = 1'b1;
                dec.opr1 = rs1_data;
                dec.opr2 = imm_i;
                dec.wb_e = 1'b1;
                case (funct3)
                    3'b000:  dec.alu_op = ALU_ADD;
                    3'b010:  dec.alu_op = ALU_SLT;
                    3'b011:  dec.alu_op = ALU_SLTU;
                    3'b100:  dec.alu_op = ALU_XOR;
                    3'b110:  dec.alu_op = ALU_OR;
                    3'b111:  dec.alu_op = ALU_AND;
                    3'b001: begin
                        dec.alu_op = ALU_SLL;
                        if (funct7 != 7'b0000000) ill = 1'b1;
                    end
                    3'b101: begin
                        if (funct7 == 7'b0000000)      dec.alu_op = ALU_SRL;
                        else if (funct7 == 7'b0100000) dec.alu_op = ALU_SRA;
                        else                           ill = 1'b1;
                    end
                    default: ill = 1'b1;
                endcase
            end
            OPC_OP: begin
                use_rs1  = 1'b1;
                use_rs2  = 1'b1;
                dec.opr1 = rs1_data;
                dec.opr2 = rs2_data;
                dec.wb_e = 1'b1;
                case (funct7)
                    7'b0000000: begin
                        case (funct3)
                            3'b000:  dec.alu_op = ALU_ADD;
                            3'b001:  dec.alu_op = ALU_SLL;
                            3'b010:  dec.alu_op = ALU_SLT;
                            3'b011:  dec.alu_op = ALU_SLTU;
                            3'b100:  dec.alu_op = ALU_XOR;
                            3'b101:  dec.alu_op = ALU_SRL;
                            3'b110:  dec.alu_op = ALU_OR;
                            default: dec.alu_op = ALU_AND;
                        endcase
                    end
                    7'b0100000: begin
                        case (funct3)
                            3'b000:  dec.alu_op = ALU_SUB;
                            3'b101:  dec.alu_op = ALU_SRA;
                            default: ill = 1'b1;
                        endcase
                    end
`ifdef PIPE_DECODE_RV32M_EN
                    7'b0000001: begin
                        case (funct3)
                            3'b000:  dec.alu_op = ALU_MUL;
                            3'b001:  dec.alu_op = ALU_MULH;
                            3'b010:  dec.alu_op = ALU_MULHSU;
                            3'b011:  dec.alu_op = ALU_MULHU;
                            3'b100:  dec.alu_op = ALU_DIV;
                            3'b101:  dec.alu_op = ALU_DIVU;
                            3'b110:  dec.alu_op = ALU_REM;
                            default: dec.alu_op = ALU_REMU;
                        endcase
                    end
`endif
                    default: ill = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                use_rs1  = 1'b1;
                dec.opr1 = rs1_data;
                dec.opr2 = imm_i;
                dec.wb_e = 1'b1;
                // rw_e[0] marks zero-extension (LBU/LHU)
                case (funct3)
                    3'b000:  begin dec.rw_e = 2'b10; dec.rw_len = 2'b00; end
                    3'b001:  begin dec.rw_e = 2'b10; dec.rw_len = 2'b01; end
                    3'b010:  begin dec.rw_e = 2'b10; dec.rw_len = 2'b11; end
                    3'b100:  begin dec.rw_e = 2'b11; dec.rw_len = 2'b00; end
                    3'b101:  begin dec.rw_e = 2'b11; dec.rw_len = 2'b01; end
                    default: ill = 1'b1;
                endcase
            end
            OPC_STORE: begin
                use_rs1  = 1'b1;
                use_rs2  = 1'b1;
                dec.opr1 = rs1_data;
                dec.opr2 = imm_s;
                dec.val  = rs2_data;
                dec.rw_e = 2'b01;
                case (funct3)
                    3'b000:  dec.rw_len = 2'b00;
                    3'b001:  dec.rw_len = 2'b01;
                    3'b010:  dec.rw_len = 2'b11;
                    default: ill = 1'b1;
                endcase
            end
            OPC_BRANCH: begin
                use_rs1  = 1'b1;
                use_rs2  = 1'b1;
                dec.opr1 = rs1_data;
                dec.opr2 = rs2_data;
                dec.val  = imm_b;
                dec.br_e = 1'b1;
                // BNE/BGE/BGEU are the inverted forms of BEQ/BLT/BLTU
                dec.alu_c = funct3[0];
                case (funct3[2:1])
                    2'b00:   dec.alu_op = ALU_SEQ;
                    2'b10:   dec.alu_op = ALU_SLT;
                    2'b11:   dec.alu_op = ALU_SLTU;
                    default: ill = 1'b1;
                endcase
            end
            OPC_MISC_MEM: begin
                dec.alu_op = ALU_ADD;
            end
            OPC_SYSTEM: begin
                dec.alu_op = ALU_PASS;
            end
            default: ill = 1'b1;
        endcase

        // An illegal word travels as an otherwise empty bundle so nothing
        // downstream acts on partially decoded fields.
        if (ill) begin
            dec         = '0;
            dec.pc      = fe.pc_in;
            dec.illegal = 1'b1;
            use_rs1     = 1'b0;
            use_rs2     = 1'b0;
        end

        // rd is only meaningful when the instruction writes back; zeroing it
        // otherwise keeps the load-use comparison from matching imm bits.
        dec.rd = dec.wb_e ? fe.inst[11:7] : 5'd0;
    end

    assign stall = held_valid && held.rw_e[1] && (held.rd != 5'd0) &&
                   ((use_rs1 && (rs1_idx == held.rd)) ||
                    (use_rs2 && (rs2_idx == held.rd)));

    assign fe.in_ready = !flush && !stall && (!held_valid || ex.out_ready);
    assign in_fire     = fe.in_valid && fe.in_ready;
    assign out_fire    = held_valid && ex.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_valid <= 1'b0;
            held       <= '0;
        end else if (flush) begin
            held_valid <= 1'b0;
        end else if (in_fire) begin
            held_valid <= 1'b1;
            held       <= dec;
        end else if (out_fire) begin
            held_valid <= 1'b0;
        end
    end

    assign ex.out_valid = held_valid;
    assign ex.pc_out    = held.pc;
    assign ex.alu_op    = held.alu_op;
    assign ex.alu_c     = held.alu_c;
    assign ex.rd        = held.rd;
    assign ex.opr1      = held.opr1;
    assign ex.opr2      = held.opr2;
    assign ex.val       = held.val;
    assign ex.jp_e      = held.jp_e;
    assign ex.br_e      = held.br_e;
    assign ex.wb_e      = held.wb_e;
    assign ex.rw_e      = held.rw_e;
    assign ex.rw_len    = held.rw_len;
    assign ex.illegal   = held.illegal;

endmodule

// File: tb/tb_pipe_decode.sv
// Self-checking bench for pipe_decode (XLEN=32, ALUOP_L=5).
// Table-driven decode vectors through a scoreboard queue, plus hand
// sequences for load-use stall, backpressure/flush and mid-stream reset.

module tb_pipe_decode;

    localparam logic [4:0] A_ADD  = 5'd0;
    localparam logic [4:0] A_SUB  = 5'd1;
    localparam logic [4:0] A_SLTU = 5'd4;
    localparam logic [4:0] A_SRA  = 5'd7;
    localparam logic [4:0] A_AND  = 5'd9;
    localparam logic [4:0] A_SEQ  = 5'd10;
    localparam logic [4:0] A_PASS = 5'd11;
    localparam logic [4:0] A_MUL  = 5'd16;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  alu_op;
        logic        alu_c;
        logic [4:0]  rd;
        logic [31:0] opr1;
        logic [31:0] opr2;
        logic [31:0] val;
        logic        jp;
        logic        br;
        logic        wb;
        logic [1:0]  rw_e;
        logic [1:0]  rw_len;
        logic        ill;
    } exp_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] rs1d;
        logic [31:0] rs2d;
        exp_t        e;
    } vec_t;

    localparam int N = 19;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic [4:0]  rs1_idx;
    logic [4:0]  rs2_idx;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;

    int passed;
    int total;
    exp_t sbq[$];
    vec_t tbl[N];

    pipe_decode_in_if  #(.XLEN(32))                fe ();
    pipe_decode_out_if #(.XLEN(32), .ALUOP_L(5))   ex ();

    pipe_decode #(.XLEN(32), .ALUOP_L(5)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .fe       (fe),
        .ex       (ex),
        .flush    (flush),
        .rs1_idx  (rs1_idx),
        .rs2_idx  (rs2_idx),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passed, total);
        $fatal(1);
    end

    function automatic exp_t mk(input logic [31:0] pc, input logic [4:0] op, input logic c,
                                input logic [4:0] rd, input logic [31:0] o1, input logic [31:0] o2,
                                input logic [31:0] v, input logic jp, input logic br, input logic wb,
                                input logic [1:0] rwe, input logic [1:0] rwl, input logic ill);
        exp_t e;
        e.pc = pc; e.alu_op = op; e.alu_c = c; e.rd = rd;
        e.opr1 = o1; e.opr2 = o2; e.val = v;
        e.jp = jp; e.br = br; e.wb = wb;
        e.rw_e = rwe; e.rw_len = rwl; e.ill = ill;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        else
            passed++;
    endtask

    task automatic check_bundle(input exp_t e);
        chk("pc_out",  ex.pc_out,  e.pc);
        chk("alu_op",  ex.alu_op,  e.alu_op);
        chk("alu_c",   ex.alu_c,   e.alu_c);
        chk("rd",      ex.rd,      e.rd);
        chk("opr1",    ex.opr1,    e.opr1);
        chk("opr2",    ex.opr2,    e.opr2);
        chk("val",     ex.val,     e.val);
        chk("jp_e",    ex.jp_e,    e.jp);
        chk("br_e",    ex.br_e,    e.br);
        chk("wb_e",    ex.wb_e,    e.wb);
        chk("rw_e",    ex.rw_e,    e.rw_e);
        chk("rw_len",  ex.rw_len,  e.rw_len);
        chk("illegal", ex.illegal, e.ill);
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic step(input exp_t e, output bit acc);
        exp_t x;
        #1;
        acc = fe.in_valid && fe.in_ready;
        if (ex.out_valid && ex.out_ready) begin
            if (sbq.size() == 0) begin
                chk("unexpected out_valid", 32'd1, 32'd0);
            end else begin
                x = sbq.pop_front();
                check_bundle(x);
            end
        end else if (flush && ex.out_valid && sbq.size() > 0) begin
            void'(sbq.pop_front());
        end
        if (acc) sbq.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [31:0] inst, input logic [31:0] pc,
                         input logic [31:0] r1, input logic [31:0] r2);
        fe.in_valid = 1'b1;
        fe.inst     = inst;
        fe.pc_in    = pc;
        rs1_data    = r1;
        rs2_data    = r2;
    endtask

    task automatic drain();
        bit acc;
        fe.in_valid  = 1'b0;
        ex.out_ready = 1'b1;
        for (int t = 0; t < 20 && sbq.size() > 0; t++) step('0, acc);
        chk("drain empty", sbq.size(), 0);
    endtask

    initial begin
        bit   acc;
        exp_t e_lw;
        exp_t e_add;
        exp_t e_addi;
        exp_t e_sub;

        passed = 0; total = 0;
        rst_n = 1'b0; flush = 1'b0;
        fe.in_valid = 1'b0; fe.inst = '0; fe.pc_in = '0;
        rs1_data = '0; rs2_data = '0; ex.out_ready = 1'b0;

        tbl[0]  = '{32'h00500093, 32'h100, 32'h0,        32'h0,    mk(32'h100, A_ADD,  0, 5'd1,  32'h0,        32'h5,        32'h0,        0, 0, 1, 2'b00, 2'b00, 0)};
        tbl[1]  = '{32'h123452B7, 32'h104, 32'h0,        32'h0,    mk(32'h104, A_PASS, 0, 5'd5,  32'h12345000, 32'h0,        32'h0,        0, 0, 1, 2'b00, 2'b00, 0)};
        tbl[2]  = '{32'hFFFFF317, 32'h200, 32'h0,        32'h0,    mk(32'h200, A_ADD,  0, 5'd6,  32'h200,      32'hFFFFF000, 32'h0,        0, 0, 1, 2'b00, 2'b00, 0)};
        tbl[3]  = '{32'h010000EF, 32'h300, 32'h0,        32'h0,    mk(32'h300, A_ADD,  0, 5'd1,  32'h10,       32'h300,      32'h4,        1, 0, 1, 2'b00, 2'b00, 0)};
        tbl[4]  = '{32'h00008067, 32'h304, 32'h1000,     32'h0,    mk(32'h304, A_ADD,  0, 5'd0,  32'h1000,     32'h0,        32'h4,        1, 0, 1, 2'b00, 2'b00, 0)};
        tbl[5]  = '{32'h402081B3, 32'h308, 32'hA,        32'h3,    mk(32'h308, A_SUB,  0, 5'd3,  32'hA,        32'h3,        32'h0,        0, 0, 1, 2'b00, 2'b00, 0)};
        tbl[6]  = '{32'h4030D213, 32'h30C, 32'h80000000, 32'h0,    mk(32'h30C, A_SRA,  0, 5'd4,  32'h80000000, 32'h403,      32'h0,        0, 0, 1, 2'b00, 2'b00, 0)};
        tbl[7]  = '{32'hFFF0C383, 32'h310, 32'h2000,     32'h0,    mk(32'h310, A_ADD,  0, 5'd7,  32'h2000,     32'hFFFFFFFF, 32'h0,        0, 0, 1, 2'b11, 2'b00, 0)};
        tbl[8]  = '{32'h00209323, 32'h314, 32'h40,       32'hBEEF, mk(32'h314, A_ADD,  0, 5'd0,  32'h40,       32'h6,        32'hBEEF,     0, 0, 0, 2'b01, 2'b01, 0)};
        tbl[9]  = '{32'h00209463, 32'h318, 32'h7,        32'h9,    mk(32'h318, A_SEQ,  1, 5'd0,  32'h7,        32'h9,        32'h8,        0, 1, 0, 2'b00, 2'b00, 0)};
        tbl[10] = '{32'hFE20FEE3, 32'h31C, 32'h5,        32'h6,    mk(32'h31C, A_SLTU, 1, 5'd0,  32'h5,        32'h6,        32'hFFFFFFFC, 0, 1, 0, 2'b00, 2'b00, 0)};
        tbl[11] = '{32'h0000000F, 32'h320, 32'h0,        32'h0,    mk(32'h320, A_ADD,  0, 5'd0,  32'h0,        32'h0,        32'h0,        0, 0, 0, 2'b00, 2'b00, 0)};
        tbl[12] = '{32'h00000073, 32'h324, 32'h0,        32'h0,    mk(32'h324, A_PASS, 0, 5'd0,  32'h0,        32'h0,        32'h0,        0, 0, 0, 2'b00, 2'b00, 0)};
        tbl[13] = '{32'hFFFFFFFF, 32'h328, 32'h0,        32'h0,    mk(32'h328, A_ADD,  0, 5'd0,  32'h0,        32'h0,        32'h0,        0, 0, 0, 2'b00, 2'b00, 1)};
        tbl[14] = '{32'h040081B3, 32'h32C, 32'h1,        32'h2,    mk(32'h32C, A_ADD,  0, 5'd0,  32'h0,        32'h0,        32'h0,        0, 0, 0, 2'b00, 2'b00, 1)};
`ifdef PIPE_DECODE_RV32M_EN
        tbl[15] = '{32'h022081B3, 32'h330, 32'h3,        32'h4,    mk(32'h330, A_MUL,  0, 5'd3,  32'h3,        32'h4,        32'h0,        0, 0, 1, 2'b00, 2'b00, 0)};
`else
        tbl[15] = '{32'h022081B3, 32'h330, 32'h3,        32'h4,    mk(32'h330, A_ADD,  0, 5'd0,  32'h0,        32'h0,        32'h0,        0, 0, 0, 2'b00, 2'b00, 1)};
`endif
        tbl[16] = '{32'hFFF0B413, 32'h334, 32'h1,        32'h0,    mk(32'h334, A_SLTU, 0, 5'd8,  32'h1,        32'hFFFFFFFF, 32'h0,        0, 0, 1, 2'b00, 2'b00, 0)};
        tbl[17] = '{32'h0020F4B3, 32'h338, 32'hF0,       32'h3C,   mk(32'h338, A_AND,  0, 5'd9,  32'hF0,       32'h3C,       32'h0,        0, 0, 1, 2'b00, 2'b00, 0)};
        tbl[18] = '{32'h00401503, 32'h33C, 32'h0,        32'h0,    mk(32'h33C, A_ADD,  0, 5'd10, 32'h0,        32'h4,        32'h0,        0, 0, 1, 2'b10, 2'b01, 0)};

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset out_valid", ex.out_valid, 0);
        chk("reset in_ready",  fe.in_ready,  1);
        chk("reset alu_op",    ex.alu_op,    0);
        chk("reset illegal",   ex.illegal,   0);
        chk("reset opr2",      ex.opr2,      0);
        chk("reset wb_e",      ex.wb_e,      0);
        rst_n = 1'b1;
        @(negedge clk);

        // Decode table through the scoreboard with random backpressure
        for (int i = 0; i < N; i++) begin
            drive(tbl[i].inst, tbl[i].pc, tbl[i].rs1d, tbl[i].rs2d);
            acc = 1'b0;
            for (int t = 0; t < 20 && !acc; t++) begin
                ex.out_ready = ($urandom_range(0, 3) != 0);
                step(tbl[i].e, acc);
            end
            if (!acc) chk("accept timeout", 32'd0, 32'd1);
        end
        drain();

        // Load-use interlock: LW x2,0(x1) then ADD x3,x2,x1
        e_lw  = mk(32'h400, A_ADD, 0, 5'd2, 32'h100, 32'h0,  32'h0, 0, 0, 1, 2'b10, 2'b11, 0);
        e_add = mk(32'h404, A_ADD, 0, 5'd3, 32'h11,  32'h22, 32'h0, 0, 0, 1, 2'b00, 2'b00, 0);
        ex.out_ready = 1'b1;
        drive(32'h0000A103, 32'h400, 32'h100, 32'h0);
        step(e_lw, acc);
        chk("lw accepted", acc, 1);
        drive(32'h001101B3, 32'h404, 32'h11, 32'h22);
        #1;
        chk("load-use in_ready", fe.in_ready, 0);
        step(e_add, acc);
        chk("load-use not accepted", acc, 0);
        chk("bubble out_valid", ex.out_valid, 0);
        chk("post-bubble in_ready", fe.in_ready, 1);
        step(e_add, acc);
        chk("dependent accepted", acc, 1);
        fe.in_valid = 1'b0;
        step('0, acc);
        chk("load-use scoreboard empty", sbq.size(), 0);

        // Backpressure then flush
        e_addi = mk(32'h500, A_ADD, 0, 5'd1, 32'h0, 32'h5, 32'h0, 0, 0, 1, 2'b00, 2'b00, 0);
        e_sub  = mk(32'h504, A_SUB, 0, 5'd3, 32'hA, 32'h3, 32'h0, 0, 0, 1, 2'b00, 2'b00, 0);
        ex.out_ready = 1'b0;
        drive(32'h00500093, 32'h500, 32'h0, 32'h0);
        step(e_addi, acc);
        chk("bp first accepted", acc, 1);
        drive(32'h402081B3, 32'h504, 32'hA, 32'h3);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("bp in_ready",  fe.in_ready,  0);
            chk("bp out_valid", ex.out_valid, 1);
            chk("bp opr2",      ex.opr2,      32'h5);
            chk("bp pc_out",    ex.pc_out,    32'h500);
            step(e_sub, acc);
            chk("bp not accepted", acc, 0);
        end
        flush = 1'b1;
        #1;
        chk("flush in_ready", fe.in_ready, 0);
        step(e_sub, acc);
        chk("flush drops input", acc, 0);
        flush = 1'b0;
        fe.in_valid = 1'b0;
        ex.out_ready = 1'b1;
        chk("flush out_valid", ex.out_valid, 0);
        step('0, acc);
        chk("flush stays empty", ex.out_valid, 0);
        chk("flush scoreboard empty", sbq.size(), 0);

        // Reset while a bundle is held
        ex.out_ready = 1'b0;
        drive(32'h00500093, 32'h600, 32'h0, 32'h0);
        step(mk(32'h600, A_ADD, 0, 5'd1, 32'h0, 32'h5, 32'h0, 0, 0, 1, 2'b00, 2'b00, 0), acc);
        fe.in_valid = 1'b0;
        chk("pre-reset out_valid", ex.out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset out_valid", ex.out_valid, 0);
        chk("async reset opr2",      ex.opr2,      0);
        chk("async reset rd",        ex.rd,        0);
        sbq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("after reset in_ready", fe.in_ready, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pipe_decode.md
# pipe_decode

Second-generation RV32I instruction-decode stage between the fetch buffer and the ALU/execute stage. It replaces event-driven decoding with a fully synchronous, one-cycle-latency pipeline register with a valid/ready handshake on both sides. It adds two combinational register-file read ports, a load-use interlock, flush support, and illegal-instruction reporting. Operand width is parametrised by XLEN.

## Interface
- XLEN, 32: operand/PC datapath width (32 or 64); immediates sign-extend to XLEN.
- ALUOP_L, 5: width of alu_op; encodings from alu_opcode.v.
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  fetch presents inst/pc_in.
- in_ready  out  1  decoder accepts this cycle.
- inst  in  32  instruction word.
- pc_in  in  XLEN  PC of inst.
- rs1_idx, rs2_idx  out  5 each  register-file read addresses (combinational from inst).
- rs1_data, rs2_data  in  XLEN each  register-file read data, same cycle.
- flush  in  1  kill the held output and the incoming instruction.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  execute consumes bundle.
- pc_out  out  XLEN; alu_op  out  ALUOP_L; alu_c  out  1 (invert ALU result); rd  out  5.
- opr1, opr2, val  out  XLEN each  ALU operands and store data / link offset / branch offset.
- jp_e, br_e, wb_e  out  1 each; rw_e  out  2; rw_len  out  2; illegal  out  1.

## Operation
- Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
- in_ready = !stall && (!out_valid || out_ready).
- On an input transfer, decode inst and register the full bundle with out_valid=1. If an output transfer occurs with no input transfer, out_valid drops to 0.
- Decode mapping per opcode:
  - LUI: PASS, opr1=imm_U, opr2=0.
  - AUIPC: ADD, pc, imm_U.
  - JAL: ADD, imm_J, pc; val=4.
  - JALR: ADD, rs1, imm_I; val=4.
  - OP_IMM and OP: funct3/funct7[5] select the op.
  - LOAD: ADD, rs1, imm_I; rw_e=10 (signed) or 11 (unsigned); rw_len 00/01/11 for B/H/W.
  - STORE: ADD, rs1, imm_S; val=rs2; rw_e=01.
  - BRANCH: SEQ/SLT/SLTU on rs1, rs2; alu_c=1 for BNE/BGE/BGEU; val=imm_B.
  - MISC_MEM: NOP bundle.
  - SYSTEM: PASS, wb_e=0.
- wb_e=0 for BRANCH/STORE/SYSTEM. jp_e for JAL/JALR. br_e for BRANCH.
- Unknown opcode/funct: illegal=1, wb_e=0, rw_e=00, jp_e=br_e=0, bundle still valid.
- Load-use stall: stall=1 when out_valid, the held bundle has rw_e[1]=1 and rd≠0, and the incoming inst reads that rd as rs1 or rs2 (only fields actually used by the opcode). Once the load transfers out, out_valid drops for one cycle (bubble); the dependent instruction is accepted the next cycle.
- flush: next edge out_valid=0. The input is not accepted (in_ready=0 while flush=1). Flush dominates every other event.

## Timing
- Reset (async, rst_n=0): out_valid=0 and every bundle output 0, including illegal and alu_op. in_ready follows its equation (1 after reset).
- Latency: 1 cycle from input transfer to out_valid.
- Throughput: 1 instruction/cycle with no stall.
- Backpressure: while out_valid && !out_ready, the bundle holds stable and in_ready=0.
- Simultaneous out transfer + in transfer: new bundle loads, out_valid stays 1.
- rs*_data is sampled on the input-transfer edge only.
- Reset mid-stream discards the held bundle immediately.

## Configuration
- PIPE_DECODE_RV32M_EN defined: OP with funct7=0000001 decodes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU to the matching alu_opcode.v ops, wb_e=1.
- Undefined: those encodings set illegal=1 and wb_e=0.

## Test plan
- Reset, then ADDI x1,x0,5 (0x00500093), rs1_data=0 -> next cycle out_valid=1, alu_op=ADD, opr1=0, opr2=5, rd=1, wb_e=1, illegal=0.
- LW x2,0(x1) (0x0000A103) followed by ADD x3,x2,x1 (0x001101B3), out_ready=1 -> in_ready=0 for one cycle, one bubble (out_valid=0), then ADD bundle with alu_op=ADD, rd=3.
- BNE x1,x2,+8 (0x00209463), rs1=7, rs2=9 -> alu_op=SEQ, alu_c=1, val=8, br_e=1, wb_e=0.
- out_ready=0 for 3 cycles with in_valid=1 -> bundle stable, in_ready=0; flush then asserted -> out_valid=0 next cycle, incoming instruction dropped.
- MUL x3,x1,x2 (0x022081B3) -> with PIPE_DECODE_RV32M_EN, alu_op=MUL, illegal=0; without it, illegal=1, wb_e=0.
